// File: rtl/dxp_pkg.sv
// Shared constants and types for the DXP logic-unit collector stage.
package dxp_pkg;

  localparam int LANE_W = 4;

  localparam logic [1:0] FUNC_NOT = 2'b00;
  localparam logic [1:0] FUNC_AND = 2'b01;
  localparam logic [1:0] FUNC_OR  = 2'b10;
  localparam logic [1:0] FUNC_SRA = 2'b11;

  // Assembly progress; IDLE means the next accepted nibble is index 0.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/dxp_flag_gen.sv
// Zero and negative flags for a word about to be loaded into the output register.
module dxp_flag_gen #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  output logic             o_z,
  output logic             o_n
);

  assign o_z = (i_word == '0);
  assign o_n = i_word[WIDTH-1];

endmodule

// File: rtl/dxp_lu_collect.sv
// Collects NIBBLES consecutive 4-bit LU lane results into one word with Z/N/C flags,
// presented on a valid/ready output register for writeback.
module dxp_lu_collect
  import dxp_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic                      In_First,
  input  logic [2:1]                Func_Sel,
  input  logic [LANE_W-1:0]         lu_out,
  input  logic                      carryout,
  output logic                      Out_Valid,
  input  logic                      Out_Ready,
  output logic [LANE_W*NIBBLES-1:0] Word_Out,
  output logic [1:0]                Func_Out,
  output logic                      Flag_Z,
  output logic                      Flag_N,
  output logic                      Flag_C,
  output logic                      Seq_Err
);

  localparam int WORD_W = LANE_W * NIBBLES;
  localparam int ASM_W  = LANE_W * (NIBBLES - 1);
  localparam int CNT_W  = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  if (NIBBLES < 2 || NIBBLES > 16) begin : g_bad_nibbles
    $error("dxp_lu_collect: NIBBLES must be in 2..16");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [ASM_W-1:0]  r_asm;
  logic [1:0]        r_func_cap;
  logic              r_carry_cap;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_func_out;
  logic              r_z;
  logic              r_n;
  logic              r_c;
  logic              r_seq_err;

  fill_state_e       w_state;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_restart;
  logic              w_load;
  logic              w_err;
  logic [WORD_W-1:0] w_word;
  logic              w_z;
  logic              w_n;

  assign w_state = (r_cnt == '0) ? ST_IDLE : ST_FILL;

  // Only the last nibble can stall: it needs the output register to be free or draining.
  assign w_in_ready = !((r_cnt == LAST) && r_out_valid && !Out_Ready);
  assign w_accept   = In_Valid && w_in_ready;

  // Any In_First, or any nibble arriving while idle, starts a new word at index 0.
  assign w_restart = In_First || (w_state == ST_IDLE);
  assign w_load    = w_accept && !w_restart && (r_cnt == LAST);

  assign w_err = w_accept && (
                   (In_First  && (w_state == ST_FILL)) ||
                   (!In_First && (w_state == ST_IDLE)) ||
                   (!In_First && (w_state == ST_FILL) && (Func_Sel != r_func_cap)));

  assign w_word = {lu_out, r_asm};

  dxp_flag_gen #(
    .WIDTH (WORD_W)
  ) u_flag_gen (
    .i_word (w_word),
    .o_z    (w_z),
    .o_n    (w_n)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_asm       <= '0;
      r_func_cap  <= FUNC_NOT;
      r_carry_cap <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_seq_err <= w_err;
      if (w_accept) begin
        if (w_restart) begin
          r_asm[LANE_W-1:0] <= lu_out;
          r_func_cap        <= Func_Sel;
          r_carry_cap       <= carryout;
          r_cnt             <= CNT_W'(1);
        end else if (r_cnt == LAST) begin
          r_cnt <= '0;
        end else begin
          r_asm[LANE_W*r_cnt +: LANE_W] <= lu_out;
          r_cnt                         <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // A completing word takes priority over the drain, so back-to-back words need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_word      <= '0;
      r_func_out  <= FUNC_NOT;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_word      <= w_word;
      r_func_out  <= r_func_cap;
      r_z         <= w_z;
      r_n         <= w_n;
      r_c         <= r_carry_cap;
    end else if (r_out_valid && Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign In_Ready  = w_in_ready;
  assign Out_Valid = r_out_valid;
  assign Word_Out  = r_word;
  assign Func_Out  = r_func_out;
  assign Flag_Z    = r_z;
  assign Flag_N    = r_n;
  assign Flag_C    = r_c;
  assign Seq_Err   = r_seq_err;

endmodule

// File: tb/tb_dxp_lu_collect.sv
// Self-checking bench for dxp_lu_collect: directed scenarios plus randomized traffic
// against a queue-based word-assembly model.
module tb_dxp_lu_collect;

  localparam int NIBBLES = 8;
  localparam int W       = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          In_Valid;
  logic          In_Ready;
  logic          In_First;
  logic [1:0]    Func_Sel;
  logic [3:0]    lu_out;
  logic          carryout;
  logic          Out_Valid;
  logic          Out_Ready;
  logic [W-1:0]  Word_Out;
  logic [1:0]    Func_Out;
  logic          Flag_Z;
  logic          Flag_N;
  logic          Flag_C;
  logic          Seq_Err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           part[$];
  logic [1:0]   m_func;
  bit           m_carry;
  bit           m_ov;
  logic [W-1:0] m_word;
  logic [1:0]   m_fout;
  bit           m_z, m_n, m_c, m_err;

  dxp_lu_collect #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_First  (In_First),
    .Func_Sel  (Func_Sel),
    .lu_out    (lu_out),
    .carryout  (carryout),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Word_Out  (Word_Out),
    .Func_Out  (Func_Out),
    .Flag_Z    (Flag_Z),
    .Flag_N    (Flag_N),
    .Flag_C    (Flag_C),
    .Seq_Err   (Seq_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    part.delete();
    m_func = 2'b00; m_carry = 0; m_ov = 0; m_word = '0; m_fout = 2'b00;
    m_z = 0; m_n = 0; m_c = 0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    if (Out_Valid !== m_ov) begin
      failures++;
      $display("FAIL %s Out_Valid got=%0b exp=%0b t=%0t", tag, Out_Valid, m_ov, $time);
    end
    checks++;
    if (Word_Out !== m_word) begin
      failures++;
      $display("FAIL %s Word_Out got=%h exp=%h t=%0t", tag, Word_Out, m_word, $time);
    end
    checks++;
    if ({Func_Out, Flag_Z, Flag_N, Flag_C} !== {m_fout, m_z, m_n, m_c}) begin
      failures++;
      $display("FAIL %s func/ZNC got=%b exp=%b t=%0t", tag,
               {Func_Out, Flag_Z, Flag_N, Flag_C}, {m_fout, m_z, m_n, m_c}, $time);
    end
    checks++;
    if (Seq_Err !== m_err) begin
      failures++;
      $display("FAIL %s Seq_Err got=%0b exp=%0b t=%0t", tag, Seq_Err, m_err, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check ready, update model at posedge, check outputs.
  task automatic cycle(input bit v, input bit first, input logic [1:0] fs,
                       input logic [3:0] d, input bit co, input bit ordy,
                       output bit accepted);
    bit rdy, err, load, ov_old;
    logic [W-1:0] w;
    In_Valid = v; In_First = first; Func_Sel = fs; lu_out = d; carryout = co;
    Out_Ready = ordy;
    #1;
    rdy = !(part.size() == NIBBLES - 1 && m_ov && !ordy);
    checks++;
    if (In_Ready !== rdy) begin
      failures++;
      $display("FAIL in_ready got=%0b exp=%0b t=%0t", In_Ready, rdy, $time);
    end
    accepted = v && rdy;
    @(posedge clk);
    err = 0; load = 0; ov_old = m_ov;
    if (accepted) begin
      if (first || part.size() == 0) begin
        err = (part.size() != 0) || !first;
        part.delete();
        part.push_back(int'(d));
        m_func = fs; m_carry = co;
      end else begin
        err = (fs != m_func);
        part.push_back(int'(d));
        if (part.size() == NIBBLES) begin
          w = '0;
          for (int k = 0; k < NIBBLES; k++) w = w | (W'(part[k]) << (4 * k));
          m_word = w; m_fout = m_func; m_z = (w == '0); m_n = w[W-1]; m_c = m_carry;
          load = 1;
          part.delete();
        end
      end
    end
    if (load) m_ov = 1;
    else if (ov_old && ordy) m_ov = 0;
    m_err = err;
    @(negedge clk);
    check_outputs("cycle");
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 2'b00, 4'h0, 0, ordy, acc);
  endtask

  task automatic send(input bit first, input logic [1:0] fs, input logic [3:0] d,
                      input bit co, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(1, first, fs, d, co, ordy, acc);
      n++;
    end while (!acc && n < 16);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout nibble=%h not accepted within 16 cycles", d);
    end
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] w,
                            input logic [1:0] f, input bit z, input bit n, input bit c);
    checks++;
    if ({Out_Valid, Word_Out, Func_Out, Flag_Z, Flag_N, Flag_C} !== {1'b1, w, f, z, n, c}) begin
      failures++;
      $display("FAIL %s got v=%0b w=%h f=%b znc=%b%b%b exp v=1 w=%h f=%b znc=%b%b%b", tag,
               Out_Valid, Word_Out, Func_Out, Flag_Z, Flag_N, Flag_C, w, f, z, n, c);
    end
  endtask

  task automatic check_async_zero(input string tag);
    checks++;
    if ({Out_Valid, Word_Out, Func_Out, Flag_Z, Flag_N, Flag_C, Seq_Err, In_Ready} !==
        {1'b0, {W{1'b0}}, 2'b00, 3'b000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL %s reset outputs v=%0b w=%h f=%b znc=%b%b%b err=%0b rdy=%0b", tag,
               Out_Valid, Word_Out, Func_Out, Flag_Z, Flag_N, Flag_C, Seq_Err, In_Ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1; In_Valid = 0; In_First = 0; Func_Sel = 0; lu_out = 0; carryout = 0;
    Out_Ready = 1;
    #2 rst_n = 0;
    #1 check_async_zero("power_on");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(2, 1);
  endtask

  task automatic test_basic_word();
    for (int k = 0; k < 8; k++) send(k == 0, 2'b01, 4'(k + 1), 0, 1);
    check_word("basic_word", 32'h87654321, 2'b01, 0, 1, 0);
    idle(2, 1);
  endtask

  task automatic test_zero_word();
    for (int k = 0; k < 8; k++) send(k == 0, 2'b11, 4'h0, k == 0, 1);
    check_word("zero_word", 32'h0, 2'b11, 1, 0, 1);
    idle(2, 1);
  endtask

  task automatic test_back_to_back();
    bit acc;
    for (int k = 0; k < 8; k++) send(k == 0, 2'b10, 4'(k + 1), 0, 0);
    for (int k = 0; k < 7; k++) send(k == 0, 2'b10, 4'(8 - k), 0, 0);
    cycle(1, 0, 2'b10, 4'h1, 0, 0, acc);
    checks++;
    if (In_Ready !== 1'b0 || acc) begin
      failures++;
      $display("FAIL stall_last got rdy=%0b acc=%0b exp rdy=0 acc=0", In_Ready, acc);
    end
    check_word("word1_held", 32'h87654321, 2'b10, 0, 1, 0);
    cycle(1, 0, 2'b10, 4'h1, 0, 1, acc);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL release_accept got acc=0 exp acc=1");
    end
    check_word("word2_loaded", 32'h12345678, 2'b10, 0, 0, 0);
    idle(2, 1);
  endtask

  task automatic test_first_mid_word();
    for (int k = 0; k < 5; k++) send(k == 0, 2'b01, 4'(k + 1), 0, 1);
    send(1, 2'b00, 4'hF, 1, 1);
    checks++;
    if (Seq_Err !== 1'b1) begin
      failures++;
      $display("FAIL first_mid_err got=%0b exp=1", Seq_Err);
    end
    for (int k = 1; k < 8; k++) send(0, 2'b00, 4'(15 - k), 0, 1);
    check_word("first_mid_word", 32'h89ABCDEF, 2'b00, 0, 1, 1);
    idle(2, 1);
  endtask

  task automatic test_func_change();
    for (int k = 0; k < 8; k++) send(k == 0, (k == 2) ? 2'b01 : 2'b10, 4'h2, 0, 1);
    check_word("func_change_word", 32'h22222222, 2'b10, 0, 0, 0);
    idle(2, 1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) send(k == 0, 2'b01, 4'h9, 1, 1);
    #3 rst_n = 0;
    #1 check_async_zero("reset_mid_word");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) send(k == 0, 2'b11, 4'(k + 8), 0, 0);
    check_word("held_before_reset", 32'hFEDCBA98, 2'b11, 0, 1, 0);
    #3 rst_n = 0;
    #1 check_async_zero("reset_out_valid");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 8; k++) send(k == 0, 2'b01, 4'(k + 1), 0, 1);
    check_word("after_reset_word", 32'h87654321, 2'b01, 0, 1, 0);
    idle(2, 1);
  endtask

  task automatic test_random();
    bit acc, v, first, co, ordy;
    logic [1:0] fs;
    for (int i = 0; i < 600; i++) begin
      v     = ($urandom_range(0, 9) < 8);
      ordy  = ($urandom_range(0, 9) < 6);
      first = (part.size() == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 29) == 0);
      if (part.size() == 0 || first) fs = 2'($urandom_range(0, 3));
      else fs = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : m_func;
      co = 1'($urandom_range(0, 1));
      cycle(v, first, fs, 4'($urandom_range(0, 15)), co, ordy, acc);
    end
    idle(3, 1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_word();
    test_zero_word();
    test_back_to_back();
    test_first_mid_word();
    test_func_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
